deserializer_stream: RTL and testbench

Parametrised serial-to-parallel converter with a ready/valid output. Serial bits qualified by `data_val_i` are packed into words of `DATA_BUS_WIDTH` bits; bit order (MSB-first or LSB-first) is set by a parameter. `data_last_i` closes a short word early, and a bit count is reported with every word. Completed words pass through a small output FIFO, so the downstream consumer can apply back-pressure. Words that arrive when the FIFO is full are dropped and flagged.

---
 rtl/deserializer_pkg.sv | 17 +
 rtl/deser_out_fifo.sv | 52 +++++
 rtl/deserializer_stream.sv | 98 +++++++++
 tb/tb_deserializer_stream.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and width helpers for the serial-to-parallel deserializer.
package deserializer_pkg;

    function automatic int mod_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_MOD_W  = mod_width(DEFAULT_DATA_W);

    // Word record at the default width; wider instances declare the same layout locally.
    typedef struct packed {
        logic [DEFAULT_MOD_W-1:0]  mod;
        logic [DEFAULT_DATA_W-1:0] data;
    } deser_word_t;

endpackage

// File: rtl/deser_out_fifo.sv
// Show-ahead output FIFO for completed words; reads as zero while empty.
module deser_out_fifo
    import deserializer_pkg::*;
#(
    parameter type word_t = deser_word_t,
    parameter int  DEPTH  = 2
) (
    input  logic  clk_i,
    input  logic  arst_i,
    input  logic  push_i,
    input  word_t push_word_i,
    input  logic  pop_i,
    output word_t head_o,
    output logic  head_val_o,
    output logic  full_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    word_t       mem_q [DEPTH];
    logic        empty;
    logic        do_pop;
    logic        do_push;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_word_i;
    end

    assign head_val_o = !empty;
    assign head_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/deserializer_stream.sv
// Serial bit collector feeding a ready/valid word FIFO, with drop-on-full overflow flag.
module deserializer_stream
    import deserializer_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int OUT_DEPTH      = 2,
    parameter int MOD_WIDTH      = mod_width(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    input  logic                      data_last_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [MOD_WIDTH-1:0]      deser_data_mod_o,
    output logic                      deser_data_val_o,
    input  logic                      deser_data_ready_i,
    output logic                      overflow_o
);

    localparam int                CNT_W    = $clog2(DATA_BUS_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_BUS_WIDTH - 1);

    typedef struct packed {
        logic [MOD_WIDTH-1:0]      mod;
        logic [DATA_BUS_WIDTH-1:0] data;
    } word_t;

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DATA_BUS_WIDTH-1:0] buf_q, buf_d;
    logic                      overflow_q, overflow_d;
    logic [CNT_W-1:0]          pos;
    word_t                     word_d;
    word_t                     head;
    logic                      complete;
    logic                      fifo_full;
    logic                      pop;
    logic                      push;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        pos         = MSB_FIRST ? (CNT_LAST - cnt_q) : cnt_q;
        word_d      = '0;
        word_d.data = buf_q;
        word_d.data[pos] = data_i;
        word_d.mod  = MOD_WIDTH'(cnt_q) + MOD_WIDTH'(1);

        complete   = data_val_i && ((cnt_q == CNT_LAST) || data_last_i);
        pop        = deser_data_val_o && deser_data_ready_i;
        push       = complete && (!fifo_full || pop);
        overflow_d = complete && fifo_full && !pop;

        cnt_d = cnt_q;
        buf_d = buf_q;
        if (data_val_i) begin
            if (complete) begin
                cnt_d = '0;
                buf_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                buf_d = word_d.data;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q      <= '0;
            buf_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            overflow_q <= overflow_d;
        end
    end

    deser_out_fifo #(
        .word_t (word_t),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .push_i      (push),
        .push_word_i (word_d),
        .pop_i       (pop),
        .head_o      (head),
        .head_val_o  (deser_data_val_o),
        .full_o      (fifo_full)
    );

    assign deser_data_o     = head.data;
    assign deser_data_mod_o = head.mod;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_deserializer_stream.sv
// Directed bench: an MSB-first and an LSB-first instance share one serial stimulus.
module tb_deserializer_stream;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        data = 1'b0;
    logic        data_val = 1'b0;
    logic        data_last = 1'b0;
    logic        ready = 1'b1;

    logic [15:0] m_data, l_data;
    logic [4:0]  m_mod, l_mod;
    logic        m_val, l_val, m_ovf, l_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deserializer_stream #(.DATA_BUS_WIDTH(16), .MSB_FIRST(1'b1), .OUT_DEPTH(2)) dut_msb (
        .clk_i(clk), .arst_i(arst), .data_i(data), .data_val_i(data_val), .data_last_i(data_last),
        .deser_data_o(m_data), .deser_data_mod_o(m_mod), .deser_data_val_o(m_val),
        .deser_data_ready_i(ready), .overflow_o(m_ovf)
    );

    deserializer_stream #(.DATA_BUS_WIDTH(16), .MSB_FIRST(1'b0), .OUT_DEPTH(2)) dut_lsb (
        .clk_i(clk), .arst_i(arst), .data_i(data), .data_val_i(data_val), .data_last_i(data_last),
        .deser_data_o(l_data), .deser_data_mod_o(l_mod), .deser_data_val_o(l_val),
        .deser_data_ready_i(ready), .overflow_o(l_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The LSB-first instance sees the same bit sequence, so its word is the bit reversal.
    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bit(input logic b, input logic last);
        data = b;
        data_val = 1'b1;
        data_last = last;
        step();
        data = 1'b0;
        data_val = 1'b0;
        data_last = 1'b0;
    endtask

    // Sends the first nbits of w, most significant first, optionally with 1..max_gap idle cycles before each bit.
    task automatic send_bits(input logic [15:0] w, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            if (max_gap > 0) idle($urandom_range(1, max_gap));
            send_bit(w[15-i], 1'b0);
        end
    endtask

    task automatic check_head(input string tag, input logic [15:0] word, input logic [4:0] mod);
        check({tag, "_m_val"}, 32'(m_val), 32'd1);
        check({tag, "_m_data"}, 32'(m_data), 32'(word));
        check({tag, "_m_mod"}, 32'(m_mod), 32'(mod));
        check({tag, "_l_data"}, 32'(l_data), 32'(rev16(word)));
        check({tag, "_l_mod"}, 32'(l_mod), 32'(mod));
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_m_val"}, 32'(m_val), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_mod"}, 32'(m_mod), 32'd0);
        check({tag, "_l_val"}, 32'(l_val), 32'd0);
    endtask

    task automatic check_ovf(input string tag, input logic exp);
        check({tag, "_m_ovf"}, 32'(m_ovf), 32'(exp));
        check({tag, "_l_ovf"}, 32'(l_ovf), 32'(exp));
    endtask

    localparam logic [15:0] GAP_WORDS [3] = '{16'h1234, 16'hBEEF, 16'h0F0F};

    initial begin
        #2;
        check_empty("reset");
        check_ovf("reset", 1'b0);
        step();
        arst = 1'b0;
        step();

        // Full word, alternating bits.
        send_bits(16'hAAAA, 15, 0);
        check("t1_before_last_val", 32'(m_val), 32'd0);
        send_bit(1'b0, 1'b0);
        check_head("t1_word", 16'hAAAA, 5'd16);
        check("t1_l_word", 32'(l_data), 32'h5555);
        idle(1);
        check_empty("t1_one_cycle");

        // Short word closed by last, then a full word with no residue.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("t2_l_data", 32'(l_data), 32'h000B);
        check("t2_l_mod", 32'(l_mod), 32'd4);
        check("t2_m_data", 32'(m_data), 32'hD000);
        check("t2_m_mod", 32'(m_mod), 32'd4);
        idle(1);
        send_bits(16'hFFFF, 16, 0);
        check_head("t2_full", 16'hFFFF, 5'd16);
        idle(1);

        // Single-bit words back to back: one word per cycle.
        send_bit(1'b1, 1'b1);
        check_head("t2b_w0", 16'h8000, 5'd1);
        send_bit(1'b0, 1'b1);
        check_head("t2b_w1", 16'h0000, 5'd1);
        send_bit(1'b1, 1'b1);
        check_head("t2b_w2", 16'h8000, 5'd1);
        check_ovf("t2b", 1'b0);
        idle(1);
        check_empty("t2b_drain");

        // Idle gaps inside words.
        for (int w = 0; w < 3; w++) begin
            send_bits(GAP_WORDS[w], 16, 3);
            check_head("t3_gap", GAP_WORDS[w], 5'd16);
            check_ovf("t3_gap", 1'b0);
            idle(1);
            check_empty("t3_pop");
            check_ovf("t3_after", 1'b0);
        end

        // Back-pressure and overflow.
        ready = 1'b0;
        send_bits(16'h1111, 16, 0);
        send_bits(16'h2222, 16, 0);
        check_ovf("t4_before", 1'b0);
        send_bits(16'h3333, 16, 0);
        check_ovf("t4_drop", 1'b1);
        check_head("t4_hold", 16'h1111, 5'd16);
        idle(1);
        check_ovf("t4_pulse_end", 1'b0);
        idle(2);
        check_head("t4_stable", 16'h1111, 5'd16);
        ready = 1'b1;
        #1;
        check_head("t4_first", 16'h1111, 5'd16);
        step();
        check_head("t4_second", 16'h2222, 5'd16);
        step();
        check_empty("t4_drained");

        // Push and pop in the same cycle while full.
        ready = 1'b0;
        send_bits(16'h4444, 16, 0);
        send_bits(16'h5555, 16, 0);
        send_bits(16'h6666, 15, 0);
        ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check_ovf("t5_no_drop", 1'b0);
        check_head("t5_second", 16'h5555, 5'd16);
        step();
        check_head("t5_third", 16'h6666, 5'd16);
        check_ovf("t5_still", 1'b0);
        step();
        check_empty("t5_drained");

        // Reset mid-word with a word queued.
        ready = 1'b0;
        send_bits(16'h7777, 16, 0);
        check_head("t6_queued", 16'h7777, 5'd16);
        send_bits(16'hFFFF, 7, 0);
        #3;
        arst = 1'b1;
        #1;
        check_empty("t6_reset");
        check_ovf("t6_reset", 1'b0);
        step();
        arst = 1'b0;
        ready = 1'b1;
        send_bits(16'hC3A5, 16, 0);
        check_head("t6_clean", 16'hC3A5, 5'd16);
        check("t6_l_word", 32'(l_data), 32'hA5C3);
        idle(1);
        check_empty("t6_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
